// File: rtl/core_pkg.sv
// Shared constants and decode-flag indexing for the RV32I execute-stage ALU.
// Flag index order is also the result-mux priority: lower index wins.
package core_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam logic [XLEN-1:0] RESULT_RST = 32'h0;

    typedef enum logic [5:0] {
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_e;

    localparam int NUM_OPS = 33;

    function automatic logic [XLEN-1:0] b2w(input logic b);
        return {{(XLEN-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/core_alu_comb.sv
// Combinational ALU datapath: shared adders, comparators, shifters, logic unit
// and a fixed-priority result select over the one-hot decode flags.
module core_alu_comb
    import core_pkg::*;
(
    input  logic [NUM_OPS-1:0] op,
    input  logic [XLEN-1:0]    rs1,
    input  logic [XLEN-1:0]    rs2,
    input  logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0]              sum_i, sum_r, diff;
    logic [SHAMT_W-1:0]           sh_i, sh_r;
    logic                         lt_s_i, lt_u_i, lt_s_r, lt_u_r, eq_r;
    logic [NUM_OPS-1:0][XLEN-1:0] res;

    assign sum_i  = rs1 + imm;
    assign sum_r  = rs1 + rs2;
    assign diff   = rs1 - rs2;
    assign sh_i   = imm[SHAMT_W-1:0];
    assign sh_r   = rs2[SHAMT_W-1:0];
    assign lt_s_i = $signed(rs1) < $signed(imm);
    assign lt_u_i = rs1 < imm;
    assign lt_s_r = $signed(rs1) < $signed(rs2);
    assign lt_u_r = rs1 < rs2;
    assign eq_r   = rs1 == rs2;

    always_comb begin
        res           = '0;
        res[OP_ADDI]  = sum_i;
        res[OP_SLTI]  = b2w(lt_s_i);
        res[OP_SLTIU] = b2w(lt_u_i);
        res[OP_XORI]  = rs1 ^ imm;
        res[OP_ORI]   = rs1 | imm;
        res[OP_ANDI]  = rs1 & imm;
        res[OP_SLLI]  = rs1 << sh_i;
        res[OP_SRLI]  = rs1 >> sh_i;
        res[OP_SRAI]  = $unsigned($signed(rs1) >>> sh_i);
        res[OP_ADD]   = sum_r;
        res[OP_SUB]   = diff;
        res[OP_SLL]   = rs1 << sh_r;
        res[OP_SLT]   = b2w(lt_s_r);
        res[OP_SLTU]  = b2w(lt_u_r);
        res[OP_XOR]   = rs1 ^ rs2;
        res[OP_SRL]   = rs1 >> sh_r;
        res[OP_SRA]   = $unsigned($signed(rs1) >>> sh_r);
        res[OP_OR]    = rs1 | rs2;
        res[OP_AND]   = rs1 & rs2;
        res[OP_BEQ]   = b2w(eq_r);
        res[OP_BNE]   = b2w(!eq_r);
        res[OP_BLT]   = b2w(lt_s_r);
        res[OP_BGE]   = b2w(!lt_s_r);
        res[OP_BLTU]  = b2w(lt_u_r);
        res[OP_BGEU]  = b2w(!lt_u_r);
        // Loads and stores only need the effective address.
        res[OP_LB]    = sum_i;
        res[OP_LH]    = sum_i;
        res[OP_LW]    = sum_i;
        res[OP_LBU]   = sum_i;
        res[OP_LHU]   = sum_i;
        res[OP_SB]    = sum_i;
        res[OP_SH]    = sum_i;
        res[OP_SW]    = sum_i;
    end

    // Scan from lowest priority up so the lowest set index is the last write.
    always_comb begin
        result = '0;
        for (int k = NUM_OPS - 1; k >= 0; k--) begin
            if (op[k]) result = res[k];
        end
    end

endmodule

// File: rtl/core_alu.sv
// Registered RV32I execute-stage ALU: one result per cycle, 1-cycle latency,
// asynchronous active-low reset of the output register.
module core_alu
    import core_pkg::*;
(
    input  logic        rst_n,
    input  logic        clk,
    input  logic        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    input  logic        I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
    input  logic        I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    input  logic        I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    input  logic [31:0] IMM,
    output logic [31:0] RESULT
);

    logic [NUM_OPS-1:0] op;
    logic [XLEN-1:0]    alu_out;

    // Bit 0 is I_ADDI so the packed order matches op_e.
    assign op = {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB,
                 I_BGEU, I_BLTU, I_BGE, I_BLT, I_BNE, I_BEQ,
                 I_AND, I_OR, I_SRA, I_SRL, I_XOR, I_SLTU, I_SLT, I_SLL, I_SUB, I_ADD,
                 I_SRAI, I_SRLI, I_SLLI, I_ANDI, I_ORI, I_XORI, I_SLTIU, I_SLTI, I_ADDI};

    core_alu_comb u_comb (
        .op     (op),
        .rs1    (RS1),
        .rs2    (RS2),
        .imm    (IMM),
        .result (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) RESULT <= RESULT_RST;
        else        RESULT <= alu_out;
    end

endmodule

// File: tb/tb_core_alu.sv
// Scoreboard bench for core_alu: expected results queued at issue, popped and
// compared one edge later when RESULT updates.
module tb_core_alu;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] fl = '0;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    core_alu dut (
        .rst_n(rst_n), .clk(clk),
        .I_ADDI(fl[0]), .I_SLTI(fl[1]), .I_SLTIU(fl[2]), .I_XORI(fl[3]), .I_ORI(fl[4]),
        .I_ANDI(fl[5]), .I_SLLI(fl[6]), .I_SRLI(fl[7]), .I_SRAI(fl[8]),
        .I_ADD(fl[9]), .I_SUB(fl[10]), .I_SLL(fl[11]), .I_SLT(fl[12]), .I_SLTU(fl[13]),
        .I_XOR(fl[14]), .I_SRL(fl[15]), .I_SRA(fl[16]), .I_OR(fl[17]), .I_AND(fl[18]),
        .I_BEQ(fl[19]), .I_BNE(fl[20]), .I_BLT(fl[21]), .I_BGE(fl[22]), .I_BLTU(fl[23]),
        .I_BGEU(fl[24]),
        .I_LB(fl[25]), .I_LH(fl[26]), .I_LW(fl[27]), .I_LBU(fl[28]), .I_LHU(fl[29]),
        .I_SB(fl[30]), .I_SH(fl[31]), .I_SW(fl[32]),
        .RS1(rs1), .RS2(rs2), .IMM(imm), .RESULT(result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input int k, input logic [31:0] a, b, i);
        logic signed [31:0] sa;
        sa = a;
        case (k)
            1:  return ($signed(a) < $signed(i)) ? 32'h1 : 32'h0;
            2:  return (a < i) ? 32'h1 : 32'h0;
            3:  return a ^ i;
            4:  return a | i;
            5:  return a & i;
            6:  return a << i[4:0];
            7:  return a >> i[4:0];
            8:  return sa >>> i[4:0];
            9:  return a + b;
            10: return a - b;
            11: return a << b[4:0];
            12, 21: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            13, 23: return (a < b) ? 32'h1 : 32'h0;
            14: return a ^ b;
            15: return a >> b[4:0];
            16: return sa >>> b[4:0];
            17: return a | b;
            18: return a & b;
            19: return (a == b) ? 32'h1 : 32'h0;
            20: return (a != b) ? 32'h1 : 32'h0;
            22: return ($signed(a) >= $signed(b)) ? 32'h1 : 32'h0;
            24: return (a >= b) ? 32'h1 : 32'h0;
            default: return a + i;   // ADDI and all loads/stores
        endcase
    endfunction

    function automatic logic [31:0] ref_vec(input logic [32:0] f, input logic [31:0] a, b, i);
        for (int k = 0; k < 33; k++) if (f[k]) return ref_op(k, a, b, i);
        return 32'h0;
    endfunction

    task automatic issue(input string tag, input logic [32:0] f,
                         input logic [31:0] a, b, i, input logic [31:0] e);
        @(negedge clk);
        fl = f; rs1 = a; rs2 = b; imm = i;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic op1(input string tag, input int k, input logic [31:0] a, b, i,
                       input logic [31:0] e);
        logic [32:0] f;
        f = '0;
        f[k] = 1'b1;
        issue(tag, f, a, b, i, e);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) chk(tag_q.pop_front(), result, exp_q.pop_front());
    end

    task automatic drain();
        for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b, i;
        logic [32:0] f;
        int k;

        #12;
        chk("reset", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        op1("addi_lat", OP_ADDI, 32'hF0, 32'h0, 32'h0F, 32'h000000FF);
        op1("addi_hold", OP_ADDI, 32'hF0, 32'h0, 32'h0F, 32'h000000FF);

        op1("slti",  OP_SLTI,  32'h86C160F0, 32'h0, 32'h70F0680F, 32'h1);
        op1("slt",   OP_SLT,   32'h86C160F0, 32'h70F0680F, 32'h0, 32'h1);
        op1("sltiu", OP_SLTIU, 32'h86C160F0, 32'h0, 32'h70F0680F, 32'h0);
        op1("sltu",  OP_SLTU,  32'h86C160F0, 32'h70F0680F, 32'h0, 32'h0);
        op1("blt",   OP_BLT,   32'h86C160F0, 32'h70F0680F, 32'h0, 32'h1);
        op1("bge",   OP_BGE,   32'h86C160F0, 32'h70F0680F, 32'h0, 32'h0);
        op1("bltu",  OP_BLTU,  32'h86C160F0, 32'h70F0680F, 32'h0, 32'h0);
        op1("bgeu",  OP_BGEU,  32'h86C160F0, 32'h70F0680F, 32'h0, 32'h1);
        op1("beq",   OP_BEQ,   32'h86C160F0, 32'h70F0680F, 32'h0, 32'h0);
        op1("bne",   OP_BNE,   32'h86C160F0, 32'h70F0680F, 32'h0, 32'h1);
        op1("beq_eq", OP_BEQ,  32'h1234, 32'h1234, 32'h0, 32'h1);

        op1("xori", OP_XORI, 32'h0854AA35, 32'h0, 32'h0557D0BE, 32'h0D037A8B);
        op1("xor",  OP_XOR,  32'h0854AA35, 32'h0557D0BE, 32'h0, 32'h0D037A8B);
        op1("ori",  OP_ORI,  32'h0854AA35, 32'h0, 32'h0557D0BE, 32'h0D57FABF);
        op1("or",   OP_OR,   32'h0854AA35, 32'h0557D0BE, 32'h0, 32'h0D57FABF);
        op1("andi", OP_ANDI, 32'h0854AA35, 32'h0, 32'h0557D0BE, 32'h00548034);
        op1("and",  OP_AND,  32'h0854AA35, 32'h0557D0BE, 32'h0, 32'h00548034);

        op1("slli",  OP_SLLI, 32'h0E5460F5, 32'h0, 32'h4, 32'hE5460F50);
        op1("sll",   OP_SLL,  32'h0E5460F5, 32'h4, 32'h0, 32'hE5460F50);
        op1("srli",  OP_SRLI, 32'h8E5460F5, 32'h0, 32'h4, 32'h08E5460F);
        op1("srl",   OP_SRL,  32'h8E5460F5, 32'h4, 32'h0, 32'h08E5460F);
        op1("srai",  OP_SRAI, 32'h8E5460F5, 32'h1, 32'h4, 32'hF8E5460F);
        op1("sra",   OP_SRA,  32'h8E5460F5, 32'h4, 32'h0, 32'hF8E5460F);
        op1("sra_wrap",  OP_SRA,  32'h8E5460F5, 32'h24, 32'h0, 32'hF8E5460F);
        op1("slli_wrap", OP_SLLI, 32'h0E5460F5, 32'h0, 32'h24, 32'hE5460F50);

        op1("add",      OP_ADD, 32'h09439AD4, 32'h00531794, 32'h0, 32'h0996B268);
        op1("sub",      OP_SUB, 32'h09439AD4, 32'h00531794, 32'h0, 32'h08F08340);
        op1("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
        op1("sw",  OP_SW, 32'h3, 32'h0, 32'h4, 32'h7);
        op1("lw",  OP_LW, 32'h1000, 32'h0, 32'hFFFFFFFC, 32'h00000FFC);
        issue("idle", 33'h0, 32'hDEADBEEF, 32'h1, 32'h2, 32'h0);
        f = '0; f[OP_ADD] = 1'b1; f[OP_SUB] = 1'b1;
        issue("add_sub_prio", f, 32'h10, 32'h3, 32'h0, 32'h13);
        f = '0; f[OP_SW] = 1'b1; f[OP_BNE] = 1'b1;
        issue("bne_sw_prio", f, 32'h10, 32'h10, 32'h5, 32'h0);

        for (int n = 0; n < 60; n++) begin
            a = $urandom; b = $urandom; i = $urandom;
            if (n % 3 == 0) b = a;
            k = $urandom_range(0, 32);
            f = '0;
            f[k] = 1'b1;
            if (n % 5 == 0) f[$urandom_range(0, 32)] = 1'b1;
            issue($sformatf("rand%0d_op%0d", n, k), f, a, b, i, ref_vec(f, a, b, i));
        end
        drain();

        // Reset while an operation is presented: it must never appear.
        @(negedge clk);
        f = '0; f[OP_ADD] = 1'b1;
        fl = f; rs1 = 32'h55; rs2 = 32'h22;
        #2 rst_n = 1'b0;
        #1 chk("reset_async", result, 32'h0);
        @(posedge clk);
        #1 chk("reset_hold", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op1("post_reset", OP_SUB, 32'h55, 32'h22, 32'h0, 32'h33);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
